adder_leds_acc: RTL and testbench
=================================

// Module: adder_leds_acc
// PURPOSE
//  Parametrised, registered successor to the 2-bit LED adder. Takes two W-bit operands
//  (sayi1, sayi2) through a valid/ready handshake and shows the result on ACC_W LEDs.
//  Two modes: single add, or running accumulation with saturation and a sticky overflow LED.
//  Sits between the board switch/button debouncers and the LED bank.
// PARAMETERS
//  W         2  operand width (bits), >=1
//  ACC_W     6  accumulator / LED width, must be >= W+1
//  SHOW_CYC  4  cycles the result is held (ready low) after each update, >=1
//  BLINK_DIV 8  half-period of the saturation blink in cycles (only with ADDER_LEDS_BLINK_EN)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      asynchronous reset, active low
//  clr       in   1      synchronous clear of accumulator, LEDs and overflow
//  mode      in   1      0 = single add, 1 = accumulate; sampled at handshake
//  valid_in  in   1      operands valid
//  ready     out  1      block can accept operands (state IDLE)
//  sayi1     in   W      operand A, unsigned
//  sayi2     in   W      operand B, unsigned
//  leds      out  ACC_W  displayed value (registered)
//  ovf_led   out  1      sticky overflow/saturation flag
//  done      out  1      one-cycle pulse in the first cycle the new leds value is visible
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, acc=0, leds=0, ovf_led=0, done=0; ready=1 once released.
//  FSM: IDLE -> ADD -> SHOW -> IDLE.
//   IDLE: ready=1. valid_in&ready at edge E latches sayi1, sayi2, mode; next state ADD.
//   ADD : ready=0. sum = sayi1+sayi2 at W+1 bits, no loss.
//         mode0: acc = zero-extended sum. mode1: acc = acc+sum computed at ACC_W+1 bits;
//         if result > 2^ACC_W-1, acc = all ones and ovf_led<=1.
//         leds<=acc, done<=1; next state SHOW.
//   SHOW: ready=0, done=0 after first cycle; counts SHOW_CYC cycles, then IDLE.
//  Latency: handshake at edge E -> leds/done valid after edge E+2; next accept at earliest
//   edge E+2+SHOW_CYC (ready low for 1+SHOW_CYC cycles).
//  valid_in while ready=0 is ignored (not queued).
//  Mode0 never sets ovf_led (ACC_W>=W+1); it does not clear an existing ovf_led.
//  In mode1, after saturation further adds keep acc at all ones; ovf_led stays 1.
//  clr (sync) has priority over everything: acc=0, leds=0, ovf_led=0, done=0, state->IDLE.
//   clr together with valid_in: clear wins; the operands are dropped (no handshake).
//  Async reset mid-ADD/SHOW: outputs go to reset values immediately; the operation is lost.
// CONFIGURATION
//  ADDER_LEDS_BLINK_EN defined: while ovf_led=1, leds alternate between all ones and 0
//   every BLINK_DIV cycles (free-running counter, reset 0, starts on all ones).
//   The internal acc is unchanged. clr or reset stops the blink.
//  Not defined: no blink counter; leds shows acc statically (all ones when saturated).
// TESTING (W=2, ACC_W=6, SHOW_CYC=4, BLINK_DIV=8)
//  1 Reset asserted mid-SHOW -> leds=0, ovf_led=0, done=0 at once; ready=1 after release.
//  2 mode0, 3+2, valid at edge E -> leds=6'd5 and done=1 after E+2; ready=0 for 5 cycles.
//  3 mode1 from clr, 3+3 eleven times -> leds 6,12,...,60, then 63 on 11th; ovf_led=1.
//  4 valid_in held high during SHOW -> exactly one add per IDLE window; no extra done.
//  5 clr and valid_in same cycle with 1+1 -> leds=0, ovf_led=0, no done, ready=1.
//  6 BLINK_EN build, after test 3 -> leds toggle 63/0 every 8 cycles; clr -> static 0.

Source files
------------

// File: rtl/adder_leds_acc.sv
// Registered W-bit adder / saturating accumulator driving an LED bank through a valid/ready handshake.
// Optional saturation blink is enabled with the ADDER_LEDS_BLINK_EN macro.
module adder_leds_acc #(
   parameter int unsigned W        = 2,
   parameter int unsigned ACC_W    = 6,
   parameter int unsigned SHOW_CYC = 4
`ifdef ADDER_LEDS_BLINK_EN
   ,
   parameter int unsigned BLINK_DIV = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             mode,
   input  logic             valid_in,
   output logic             ready,
   input  logic [W-1:0]     sayi1,
   input  logic [W-1:0]     sayi2,
   output logic [ACC_W-1:0] leds,
   output logic             ovf_led,
   output logic             done
);

   localparam int unsigned SUM_W = W + 1;
   localparam int unsigned EXT_W = ACC_W + 1;
   localparam int unsigned CNT_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHOW} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic               mode_q, mode_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [ACC_W-1:0]   disp_q, disp_d;
   logic               sat_q, sat_d;
   logic               upd_q, upd_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]   sum_c;
   logic [EXT_W-1:0]   acc_ext_c;

   assign sum_c     = SUM_W'(a_q) + SUM_W'(b_q);
   assign acc_ext_c = EXT_W'(acc_q) + EXT_W'(sum_c);

   // Next-state logic: the add lands in acc in ADD, then becomes visible one cycle later.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      mode_d  = mode_q;
      acc_d   = acc_q;
      disp_d  = disp_q;
      sat_d   = sat_q;
      upd_d   = 1'b0;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               a_d     = sayi1;
               b_d     = sayi2;
               mode_d  = mode;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (mode_q) begin
               if (acc_ext_c[ACC_W]) begin
                  acc_d = '1;
                  sat_d = 1'b1;
               end else begin
                  acc_d = acc_ext_c[ACC_W-1:0];
                  sat_d = 1'b0;
               end
            end else begin
               acc_d = ACC_W'(sum_c);
               sat_d = 1'b0;
            end
            upd_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (cnt_q == CNT_W'(SHOW_CYC - 1)) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (upd_q) begin
         disp_d = acc_q;
         done_d = 1'b1;
         if (sat_q) ovf_d = 1'b1;
      end

      // Clear overrides everything, including a same-cycle handshake.
      if (clr) begin
         state_d = S_IDLE;
         acc_d   = '0;
         disp_d  = '0;
         sat_d   = 1'b0;
         upd_d   = 1'b0;
         ovf_d   = 1'b0;
         done_d  = 1'b0;
         cnt_d   = '0;
      end

      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         disp_q  <= '0;
         sat_q   <= 1'b0;
         upd_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mode_q  <= mode_d;
         acc_q   <= acc_d;
         disp_q  <= disp_d;
         sat_q   <= sat_d;
         upd_q   <= upd_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef ADDER_LEDS_BLINK_EN
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic              phase_q, phase_d;
   logic [ACC_W-1:0]  leds_q, leds_d;

   // Free-running blink timebase; phase 0 shows all ones.
   always_comb begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
      phase_d   = phase_q;
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_cnt_d = '0;
         phase_d   = ~phase_q;
      end
      if (clr) begin
         blk_cnt_d = '0;
         phase_d   = 1'b0;
      end
      leds_d = ovf_d ? (phase_d ? '0 : '1) : disp_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt_q <= '0;
         phase_q   <= 1'b0;
         leds_q    <= '0;
      end else begin
         blk_cnt_q <= blk_cnt_d;
         phase_q   <= phase_d;
         leds_q    <= leds_d;
      end
   end

   assign leds = leds_q;
`else
   assign leds = disp_q;
`endif

   assign ready   = ready_q;
   assign ovf_led = ovf_q;
   assign done    = done_q;

endmodule

// File: tb/tb_adder_leds_acc.sv
// Self-checking bench for adder_leds_acc: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_adder_leds_acc;

   localparam int unsigned W        = 2;
   localparam int unsigned ACC_W    = 6;
   localparam int unsigned SHOW_CYC = 4;
   localparam int          ACC_MAX  = (1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             mode = 1'b0;
   logic             valid_in = 1'b0;
   logic [W-1:0]     sayi1 = '0;
   logic [W-1:0]     sayi2 = '0;
   logic             ready;
   logic [ACC_W-1:0] leds;
   logic             ovf_led;
   logic             done;

   int checks = 0;
   int errors = 0;
   int m_acc  = 0;
   bit m_ovf  = 1'b0;

   adder_leds_acc #(.W(W), .ACC_W(ACC_W), .SHOW_CYC(SHOW_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .mode(mode), .valid_in(valid_in),
      .ready(ready), .sayi1(sayi1), .sayi2(sayi2), .leds(leds),
      .ovf_led(ovf_led), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: single add replaces, accumulate saturates at all ones and sets sticky overflow.
   task automatic model_add(input int a, input int b, input bit m);
      if (!m) begin
         m_acc = a + b;
      end else begin
         m_acc = m_acc + a + b;
         if (m_acc > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check("wait_ready", 32'(ready), 32'd1);
   endtask

   task automatic check_leds(input string tag);
`ifdef ADDER_LEDS_BLINK_EN
      if (!m_ovf) check(tag, 32'(leds), 32'(m_acc));
`else
      check(tag, 32'(leds), 32'(m_acc));
`endif
   endtask

   // One full transaction with latency/ready-window checks.
   task automatic do_op(input int a, input int b, input bit m, input string tag);
      wait_ready();
      sayi1 = W'(a);
      sayi2 = W'(b);
      mode = m;
      valid_in = 1'b1;
      step();                                   // edge E
      valid_in = 1'b0;
      model_add(a, b, m);
      check({tag, "_ready_E"}, 32'(ready), 32'd0);
      check({tag, "_done_E"}, 32'(done), 32'd0);
      step();                                   // E+1
      check({tag, "_done_E1"}, 32'(done), 32'd0);
      step();                                   // E+2
      check({tag, "_done_E2"}, 32'(done), 32'd1);
      check_leds({tag, "_leds"});
      check({tag, "_ovf"}, 32'(ovf_led), 32'(m_ovf));
      check({tag, "_ready_E2"}, 32'(ready), 32'd0);
      step();                                   // E+3
      check({tag, "_done_E3"}, 32'(done), 32'd0);
      repeat (SHOW_CYC - 3) step();             // E+SHOW_CYC
      check({tag, "_ready_last_low"}, 32'(ready), 32'd0);
      step();                                   // E+1+SHOW_CYC
      check({tag, "_ready_high"}, 32'(ready), 32'd1);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
      m_acc = 0;
      m_ovf = 1'b0;
   endtask

   initial begin
      int nd;
      int changes;
      logic [ACC_W-1:0] prev;

      // Reset state
      repeat (2) step();
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_ovf", 32'(ovf_led), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      check("rst_ready", 32'(ready), 32'd1);

      // Single add 3+2
      do_op(3, 2, 1'b0, "t2");

      // Accumulate 3+3 eleven times from clear, saturating on the last
      do_clr();
      check("t3_clr_leds", 32'(leds), 32'd0);
      for (int i = 0; i < 11; i++) do_op(3, 3, 1'b1, $sformatf("t3_%0d", i));
      check("t3_sat_ovf", 32'(ovf_led), 32'd1);

`ifdef ADDER_LEDS_BLINK_EN
      changes = 0;
      prev = leds;
      for (int i = 0; i < 40; i++) begin
         step();
         check("t6_blink_val", 32'(leds == '0 || leds == '1), 32'd1);
         if (leds != prev) changes++;
         prev = leds;
      end
      check("t6_blink_toggles", 32'(changes >= 4 && changes <= 5), 32'd1);
      do_clr();
      repeat (10) step();
      check("t6_clr_static", 32'(leds), 32'd0);
`else
      for (int i = 0; i < 4; i++) begin
         repeat (5) step();
         check("t3_static_leds", 32'(leds), 32'(ACC_MAX));
      end
      do_clr();
`endif

      // valid_in held through SHOW: one add per IDLE window
      check("t4_ready", 32'(ready), 32'd1);
      sayi1 = W'(1);
      sayi2 = W'(2);
      mode = 1'b1;
      valid_in = 1'b1;
      nd = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (done === 1'b1) nd++;
         if (i == 10) valid_in = 1'b0;
      end
      model_add(1, 2, 1'b1);
      model_add(1, 2, 1'b1);
      check("t4_done_count", 32'(nd), 32'd2);
      check("t4_leds", 32'(leds), 32'(m_acc));
      check("t4_ready_end", 32'(ready), 32'd1);

      // clr and valid_in in the same cycle
      clr = 1'b1;
      valid_in = 1'b1;
      sayi1 = W'(1);
      sayi2 = W'(1);
      mode = 1'b0;
      step();
      clr = 1'b0;
      valid_in = 1'b0;
      m_acc = 0;
      m_ovf = 1'b0;
      check("t5_leds", 32'(leds), 32'd0);
      check("t5_ovf", 32'(ovf_led), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      check("t5_ready", 32'(ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t5_no_done", 32'(done), 32'd0);
         check("t5_leds_hold", 32'(leds), 32'd0);
      end

      // Randomized operations against the model
      for (int i = 0; i < 24; i++) begin
         do_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) != 0), $sformatf("rnd_%0d", i));
      end

      // Async reset mid-SHOW
      do_op(3, 3, 1'b0, "t1_pre");
      wait_ready();
      sayi1 = W'(2);
      sayi2 = W'(2);
      mode = 1'b0;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      m_acc = 0;
      m_ovf = 1'b0;
      check("t1_leds", 32'(leds), 32'd0);
      check("t1_ovf", 32'(ovf_led), 32'd0);
      check("t1_done", 32'(done), 32'd0);
      step();
      @(negedge clk) rst_n = 1'b1;
      step();
      check("t1_ready", 32'(ready), 32'd1);
      check("t1_leds_after", 32'(leds), 32'd0);
      do_op(2, 1, 1'b1, "t1_post");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
